// File: rtl/compute_seq_ctrl_if.sv
// Command handshake between the command decoder (master) and compute_seq_ctrl (slave).
interface compute_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_W     = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_num_row;
  logic [TILE_W-1:0]     cmd_num_tile;
  logic                  cmd_weight_fill;
  logic                  cmd_accum;

  modport master (
    output cmd_valid, cmd_num_row, cmd_num_tile, cmd_weight_fill, cmd_accum,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_num_row, cmd_num_tile, cmd_weight_fill, cmd_accum,
    output cmd_ready
  );
endinterface

// File: rtl/compute_seq_ctrl.sv
// Multi-tile compute sequencer: loads/prefetches weight tiles, starts input reads
// and generates accumulator write addresses for each tile of a command.
module compute_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_DEPTH  = 256,
  parameter int TILE_W     = 8,
  localparam int ACC_AW    = $clog2(ACC_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  compute_seq_ctrl_if.slave     cmd,
  input  logic                  fill_done,
  input  logic                  row_done,
  output logic                  fifo_out_ctrl_en,
  output logic                  mem_rd_ctrl_en,
  output logic                  accum_wr_en,
  output logic [ACC_AW-1:0]     accum_wr_addr,
  output logic                  accum_mode,
  output logic [DATA_WIDTH-1:0] num_row_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, W_FILL, COMPUTE, DONE} state_t;

  state_t            state, state_d;
  logic [TILE_W-1:0] num_tile, num_tile_d;
  logic [TILE_W-1:0] tile_cnt, tile_cnt_d;
  logic [ACC_AW-1:0] row_cnt, row_cnt_d;
  logic              accum_first, accum_first_d;
  logic              prefetch, prefetch_d;

  logic                  fifo_d, mem_rd_d, wr_en_d, mode_d, done_d;
  logic [ACC_AW-1:0]     addr_d;
  logic [DATA_WIDTH-1:0] num_row_d, clamp_row;
  logic [TILE_W:0]       tile_p1, tile_p2;
  logic                  last_tile, more_after_next, row_end;

  assign cmd.cmd_ready = (state == IDLE);

  assign clamp_row = (cmd.cmd_num_row > DATA_WIDTH'(ACC_DEPTH)) ?
                     DATA_WIDTH'(ACC_DEPTH) : cmd.cmd_num_row;

  // Tile arithmetic is one bit wider so num_tile at its maximum cannot overflow.
  assign tile_p1         = {1'b0, tile_cnt} + (TILE_W+1)'(1);
  assign tile_p2         = {1'b0, tile_cnt} + (TILE_W+1)'(2);
  assign last_tile       = (tile_p1 == {1'b0, num_tile});
  assign more_after_next = (tile_p2 < {1'b0, num_tile});
  assign row_end         = (DATA_WIDTH'(row_cnt) == num_row_out - DATA_WIDTH'(1));

  always_comb begin
    state_d       = state;
    num_tile_d    = num_tile;
    tile_cnt_d    = tile_cnt;
    row_cnt_d     = row_cnt;
    accum_first_d = accum_first;
    prefetch_d    = prefetch;
    num_row_d     = num_row_out;
    fifo_d        = 1'b0;
    mem_rd_d      = 1'b0;
    wr_en_d       = 1'b0;
    done_d        = 1'b0;
    addr_d        = accum_wr_addr;
    mode_d        = accum_mode;

    unique case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          num_row_d     = clamp_row;
          num_tile_d    = cmd.cmd_num_tile;
          accum_first_d = cmd.cmd_accum;
          tile_cnt_d    = '0;
          row_cnt_d     = '0;
          prefetch_d    = 1'b0;
          if (clamp_row == '0 || cmd.cmd_num_tile == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (cmd.cmd_weight_fill) begin
            fifo_d  = 1'b1;
            state_d = W_FILL;
          end else begin
            mem_rd_d = 1'b1;
            fifo_d   = (cmd.cmd_num_tile > TILE_W'(1));
            state_d  = COMPUTE;
          end
        end
      end

      W_FILL: begin
        if (fill_done) begin
          mem_rd_d = 1'b1;
          fifo_d   = (tile_p1 < {1'b0, num_tile});
          state_d  = COMPUTE;
        end
      end

      COMPUTE: begin
        prefetch_d = prefetch | fill_done;
        if (row_done) begin
          wr_en_d = 1'b1;
          addr_d  = row_cnt;
          mode_d  = (tile_cnt == '0) ? accum_first : 1'b1;
          if (row_end) begin
            row_cnt_d = '0;
            if (last_tile) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (prefetch || fill_done) begin
              prefetch_d = 1'b0;
              tile_cnt_d = tile_p1[TILE_W-1:0];
              mem_rd_d   = 1'b1;
              fifo_d     = more_after_next;
            end else begin
              // Next tile's FIFO request is already outstanding; just wait for it.
              tile_cnt_d = tile_p1[TILE_W-1:0];
              state_d    = W_FILL;
            end
          end else begin
            row_cnt_d = row_cnt + ACC_AW'(1);
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      num_tile         <= '0;
      tile_cnt         <= '0;
      row_cnt          <= '0;
      accum_first      <= 1'b0;
      prefetch         <= 1'b0;
      fifo_out_ctrl_en <= 1'b0;
      mem_rd_ctrl_en   <= 1'b0;
      accum_wr_en      <= 1'b0;
      accum_wr_addr    <= '0;
      accum_mode       <= 1'b0;
      num_row_out      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_d;
      num_tile         <= num_tile_d;
      tile_cnt         <= tile_cnt_d;
      row_cnt          <= row_cnt_d;
      accum_first      <= accum_first_d;
      prefetch         <= prefetch_d;
      fifo_out_ctrl_en <= fifo_d;
      mem_rd_ctrl_en   <= mem_rd_d;
      accum_wr_en      <= wr_en_d;
      accum_wr_addr    <= addr_d;
      accum_mode       <= mode_d;
      num_row_out      <= num_row_d;
      busy             <= (state_d != IDLE);
      done             <= done_d;
    end
  end

endmodule

// File: tb/tb_compute_seq_ctrl.sv
// Scoreboard bench for compute_seq_ctrl: expected accumulator writes are queued by
// the stimulus and popped by an independent monitor; strobe timing is checked inline.
module tb_compute_seq_ctrl;
  localparam int DW = 16;
  localparam int AD = 256;
  localparam int TW = 8;
  localparam int AW = $clog2(AD);

  logic          clk = 1'b0;
  logic          rstn;
  logic          fill_done, row_done;
  logic          fifo_out_ctrl_en, mem_rd_ctrl_en, accum_wr_en, accum_mode, busy, done;
  logic [AW-1:0] accum_wr_addr;
  logic [DW-1:0] num_row_out;

  compute_seq_ctrl_if #(.DATA_WIDTH(DW), .TILE_W(TW)) cmd_if ();

  compute_seq_ctrl #(.DATA_WIDTH(DW), .ACC_DEPTH(AD), .TILE_W(TW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .cmd              (cmd_if),
    .fill_done        (fill_done),
    .row_done         (row_done),
    .fifo_out_ctrl_en (fifo_out_ctrl_en),
    .mem_rd_ctrl_en   (mem_rd_ctrl_en),
    .accum_wr_en      (accum_wr_en),
    .accum_wr_addr    (accum_wr_addr),
    .accum_mode       (accum_mode),
    .num_row_out      (num_row_out),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned fifo_cnt = 0;
  int unsigned mem_cnt  = 0;
  int unsigned wr_cnt   = 0;
  int unsigned wr_q[$];  // {mode, addr} packed as mode*1024 + addr

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every accumulator write.
  always @(negedge clk) begin
    if (rstn) begin
      if (fifo_out_ctrl_en) fifo_cnt++;
      if (mem_rd_ctrl_en)   mem_cnt++;
      if (accum_wr_en) begin
        int unsigned e;
        wr_cnt++;
        if (wr_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_wr: got write addr %0d mode %0d, expected none (t=%0t)",
                   accum_wr_addr, accum_mode, $time);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", accum_wr_addr, e % 1024);
          chk("wr_mode", accum_mode, e / 1024);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    fifo_cnt = 0;
    mem_cnt  = 0;
    wr_cnt   = 0;
  endtask

  task automatic send_cmd(input int unsigned rows, input int unsigned tiles,
                          input bit wf, input bit acc);
    cmd_if.cmd_num_row     = DW'(rows);
    cmd_if.cmd_num_tile    = TW'(tiles);
    cmd_if.cmd_weight_fill = wf;
    cmd_if.cmd_accum       = acc;
    cmd_if.cmd_valid       = 1'b1;
    chk("ready_before_accept", cmd_if.cmd_ready, 1);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic do_row(input int unsigned addr, input bit mode, input bit fd);
    row_done  = 1'b1;
    fill_done = fd;
    wr_q.push_back(mode * 1024 + addr);
    step();
    row_done  = 1'b0;
    fill_done = 1'b0;
  endtask

  task automatic pulse_fill();
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    step();
    chk({tag, "_ready_after"}, cmd_if.cmd_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_q_empty"}, wr_q.size(), 0);
  endtask

  initial begin
    rstn = 1'b0;
    fill_done = 1'b0;
    row_done  = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_num_row = '0;
    cmd_if.cmd_num_tile = '0;
    cmd_if.cmd_weight_fill = 1'b0;
    cmd_if.cmd_accum = 1'b0;
    step();
    step();
    chk("rst_ready", cmd_if.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", accum_wr_en, 0);
    chk("rst_num_row", num_row_out, 0);
    #2 rstn = 1'b1;
    step();

    // Single tile with weight fill.
    clr_cnt();
    send_cmd(4, 1, 1'b1, 1'b0);
    chk("t1_fifo_T1", fifo_out_ctrl_en, 1);
    chk("t1_memrd_T1", mem_rd_ctrl_en, 0);
    chk("t1_busy_T1", busy, 1);
    chk("t1_ready_T1", cmd_if.cmd_ready, 0);
    chk("t1_num_row", num_row_out, 4);
    step();
    chk("t1_fifo_single", fifo_out_ctrl_en, 0);
    pulse_fill();
    chk("t1_memrd_F1", mem_rd_ctrl_en, 1);
    chk("t1_no_prefetch", fifo_out_ctrl_en, 0);
    for (int unsigned i = 0; i < 4; i++) do_row(i, 1'b0, 1'b0);
    chk("t1_last_wr", accum_wr_en, 1);
    finish_cmd("t1");
    chk("t1_fifo_cnt", fifo_cnt, 1);
    chk("t1_mem_cnt", mem_cnt, 1);

    // Prefetched three tiles, fill_done during each of the first two tiles.
    clr_cnt();
    send_cmd(3, 3, 1'b0, 1'b1);
    chk("t2_memrd_T1", mem_rd_ctrl_en, 1);
    chk("t2_fifo_T1", fifo_out_ctrl_en, 1);
    for (int unsigned t = 0; t < 3; t++) begin
      for (int unsigned i = 0; i < 3; i++) do_row(i, 1'b1, (i == 0) && (t < 2));
      if (t < 2) begin
        chk("t2_memrd_next", mem_rd_ctrl_en, 1);
        chk("t2_fifo_next", fifo_out_ctrl_en, (t == 0) ? 1 : 0);
      end
    end
    finish_cmd("t2");
    chk("t2_fifo_cnt", fifo_cnt, 2);
    chk("t2_mem_cnt", mem_cnt, 3);

    // Late prefetch: fill_done arrives 5 cycles after tile 0 ends.
    clr_cnt();
    send_cmd(2, 2, 1'b0, 1'b0);
    do_row(0, 1'b0, 1'b0);
    do_row(1, 1'b0, 1'b0);
    for (int unsigned c = 0; c < 4; c++) begin
      chk("t3_wait_memrd", mem_rd_ctrl_en, 0);
      chk("t3_wait_fifo", fifo_out_ctrl_en, 0);
      step();
    end
    chk("t3_busy_wait", busy, 1);
    pulse_fill();
    chk("t3_memrd_F1", mem_rd_ctrl_en, 1);
    chk("t3_fifo_F1", fifo_out_ctrl_en, 0);
    do_row(0, 1'b1, 1'b0);
    do_row(1, 1'b1, 1'b0);
    finish_cmd("t3");
    chk("t3_fifo_cnt", fifo_cnt, 1);
    chk("t3_mem_cnt", mem_cnt, 2);

    // fill_done coincides with the last row of tile 0.
    clr_cnt();
    send_cmd(2, 2, 1'b0, 1'b0);
    do_row(0, 1'b0, 1'b0);
    do_row(1, 1'b0, 1'b1);
    chk("t4_memrd_next", mem_rd_ctrl_en, 1);
    chk("t4_fifo_next", fifo_out_ctrl_en, 0);
    do_row(0, 1'b1, 1'b0);
    do_row(1, 1'b1, 1'b0);
    finish_cmd("t4");
    chk("t4_mem_cnt", mem_cnt, 2);

    // Row count clamp and address wrap at ACC_DEPTH.
    clr_cnt();
    send_cmd(300, 2, 1'b0, 1'b1);
    chk("t5_num_row_clamp", num_row_out, 256);
    for (int unsigned i = 0; i < 256; i++) do_row(i, 1'b1, i == 10);
    chk("t5_memrd_tile1", mem_rd_ctrl_en, 1);
    for (int unsigned i = 0; i < 256; i++) do_row(i, 1'b1, 1'b0);
    finish_cmd("t5");
    chk("t5_wr_cnt", wr_cnt, 512);

    // Zero-length commands.
    clr_cnt();
    send_cmd(5, 0, 1'b1, 1'b0);
    chk("t6_tile0_done", done, 1);
    chk("t6_tile0_fifo", fifo_out_ctrl_en, 0);
    chk("t6_tile0_memrd", mem_rd_ctrl_en, 0);
    step();
    send_cmd(0, 3, 1'b0, 1'b0);
    chk("t6_row0_done", done, 1);
    chk("t6_row0_memrd", mem_rd_ctrl_en, 0);
    chk("t6_row0_fifo", fifo_out_ctrl_en, 0);
    step();
    chk("t6_ready", cmd_if.cmd_ready, 1);

    // row_done / fill_done while idle.
    clr_cnt();
    row_done = 1'b1;
    fill_done = 1'b1;
    step();
    step();
    row_done = 1'b0;
    fill_done = 1'b0;
    chk("t7_idle_no_wr", accum_wr_en, 0);
    step();
    chk("t7_idle_wr_cnt", wr_cnt, 0);
    chk("t7_idle_memrd_cnt", mem_cnt, 0);

    // Asynchronous reset in the middle of a tile.
    clr_cnt();
    send_cmd(4, 1, 1'b0, 1'b0);
    do_row(0, 1'b0, 1'b0);
    do_row(1, 1'b0, 1'b0);
    step();
    #2 rstn = 1'b0;
    #1;
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_wr_en", accum_wr_en, 0);
    chk("t8_rst_addr", accum_wr_addr, 0);
    chk("t8_rst_num_row", num_row_out, 0);
    chk("t8_rst_mem_fifo", {mem_rd_ctrl_en, fifo_out_ctrl_en, done}, 0);
    step();
    #2 rstn = 1'b1;
    step();
    chk("t8_ready_after", cmd_if.cmd_ready, 1);
    send_cmd(2, 1, 1'b0, 1'b1);
    chk("t8_memrd_T1", mem_rd_ctrl_en, 1);
    do_row(0, 1'b1, 1'b0);
    do_row(1, 1'b1, 1'b0);
    finish_cmd("t8");

    step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
